cla_pipe_adder: RTL

//  Parametrised two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.

---
 rtl/cla_pipe_adder_if.sv | 28 ++
 rtl/cla_pipe_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus for cla_pipe_adder: input beat handshake plus result beat with flags.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             neg;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, neg, zero
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf, neg, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-level carry-lookahead adder/subtractor (ADD/ADC/SUB/SBB) with NZCV flags,
// split across a two-stage valid/ready pipeline: S1 holds conditioned operands
// and group propagate/generate, S2 resolves carries and registers the result.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input logic            clk,
    input logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned NG = WIDTH / GROUP;

    if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : g_bad_group
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    // Occupancy encoding is {v1, v2}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ST_S2 = 2'b01,
        ST_S1 = 2'b10,
        FULL  = 2'b11
    } occ_t;

    occ_t state, state_nx;
    logic v1, v2, adv2, accept, in_ready;

    // S1 conditioning (combinational, from bus inputs)
    logic [WIDTH-1:0] b_eff, p_d, g_d;
    logic [NG-1:0]    gp_d, gg_d;
    logic             c0_eff, gterm;

    // S1 registers
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_gp, s1_gg;
    logic             s1_c0;

    // S2 carry resolution (combinational, from S1 registers)
    logic [NG-1:0]    gc;
    logic [WIDTH-1:0] cb, sum_d;
    logic             cterm, t, cgrp;

    // S2 / output registers
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, neg_q, zero_q;

    assign v1 = state[1];
    assign v2 = state[0];

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // Handshake and next occupancy; in_ready depends on out_ready only, never on in_valid
    always_comb begin
        adv2     = v1 & (~v2 | bus.out_ready);
        in_ready = rst_n & (~v1 | adv2);
        accept   = bus.in_valid & in_ready;
        state_nx = occ_t'({accept | (v1 & ~adv2), adv2 | (v2 & ~bus.out_ready)});
    end

    // Operand conditioning and per-group propagate/generate
    always_comb begin
        b_eff = bus.op[1] ? ~bus.b : bus.b;
        case (bus.op)
            2'b00:   c0_eff = 1'b0;
            2'b01:   c0_eff = bus.cin;
            2'b10:   c0_eff = 1'b1;
            default: c0_eff = ~bus.cin;
        endcase
        p_d   = bus.a ^ b_eff;
        g_d   = bus.a & b_eff;
        gp_d  = '0;
        gg_d  = '0;
        gterm = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            gp_d[k] = &p_d[k*GROUP +: GROUP];
            for (int unsigned j = 0; j < GROUP; j++) begin
                gterm = g_d[k*GROUP + j];
                for (int unsigned m = j + 1; m < GROUP; m++) gterm = gterm & p_d[k*GROUP + m];
                gg_d[k] = gg_d[k] | gterm;
            end
        end
    end

    // S1 capture on accept; contents are only observed while v1 is set
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p  <= p_d;
            s1_g  <= g_d;
            s1_gp <= gp_d;
            s1_gg <= gg_d;
            s1_c0 <= c0_eff;
        end
    end

    // Sum-of-products lookahead for group carries, then per-bit carries from each group's carry-in
    always_comb begin
        gc    = '0;
        cb    = '0;
        cterm = 1'b0;
        t     = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            cterm = s1_c0;
            for (int unsigned m = 0; m <= k; m++) cterm = cterm & s1_gp[m];
            for (int unsigned j = 0; j <= k; j++) begin
                t = s1_gg[j];
                for (int unsigned m = j + 1; m <= k; m++) t = t & s1_gp[m];
                cterm = cterm | t;
            end
            gc[k] = cterm;
        end
        cgrp = s1_c0;
        for (int unsigned k = 0; k < NG; k++) begin
            for (int unsigned j = 0; j < GROUP; j++) begin
                cterm = cgrp;
                for (int unsigned m = 0; m < j; m++) cterm = cterm & s1_p[k*GROUP + m];
                for (int unsigned r = 0; r < j; r++) begin
                    t = s1_g[k*GROUP + r];
                    for (int unsigned m = r + 1; m < j; m++) t = t & s1_p[k*GROUP + m];
                    cterm = cterm | t;
                end
                cb[k*GROUP + j] = cterm;
            end
            cgrp = gc[k];
        end
        sum_d = s1_p ^ cb;
    end

    // Result and flag registers; held while the downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv2) begin
            sum_q  <= sum_d;
            cout_q <= gc[NG-1];
            ovf_q  <= cb[WIDTH-1] ^ gc[NG-1];
            neg_q  <= sum_d[WIDTH-1];
            zero_q <= ~|sum_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v2;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.neg       = neg_q;
    assign bus.zero      = zero_q;
endmodule
